uart_irq_scheduler: RTL and testbench

- Sequential interrupt controller for the UART.
- Latches the five 16550-style interrupt sources into pending flags and runs the RX character-timeout counter.
- Applies enable gating and fixed priority, and produces a registered ISR identification/status and IRQ line.
- Sits between the RX/TX/modem datapaths plus register-file access strobes and the CPU interrupt input.

---
 rtl/uart_irq_scheduler.sv | 151 +++++++++++++++
 tb/tb_uart_irq_scheduler.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/uart_irq_scheduler.sv
// UART interrupt scheduler: latches 16550-style interrupt sources, runs the RX
// character timeout, and produces a registered prioritised ISR id/status and IRQ.
module uart_irq_scheduler #(
   parameter int unsigned TimeoutChars = 4,
   parameter int unsigned CntWidth     = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [3:0] ier_i,
   input  logic       fifo_en_i,
   input  logic       rx_line_err_i,
   input  logic       rx_data_ready_i,
   input  logic       rx_fifo_trigger_i,
   input  logic       rx_fifo_empty_i,
   input  logic       rx_fifo_push_i,
   input  logic       rx_fifo_pop_i,
   input  logic       tx_thr_empty_i,
   input  logic       modem_delta_i,
   input  logic       bit_tick_i,
   input  logic [3:0] char_bits_i,
   input  logic       rd_lsr_i,
   input  logic       rd_rhr_i,
   input  logic       rd_msr_i,
   input  logic       rd_isr_i,
   input  logic       wr_thr_i,
   output logic [2:0] isr_id_o,
   output logic       isr_status_o,
   output logic       irq_o,
   output logic       timeout_o
);

   localparam int unsigned IdWidth   = 3;
   localparam int unsigned CharWidth = 4;

   localparam logic [IdWidth-1:0] IdRls   = 3'b011;
   localparam logic [IdWidth-1:0] IdRxdr  = 3'b010;
   localparam logic [IdWidth-1:0] IdTmo   = 3'b110;
   localparam logic [IdWidth-1:0] IdThre  = 3'b001;
   localparam logic [IdWidth-1:0] IdMstat = 3'b000;
   localparam logic [IdWidth-1:0] IdNone  = 3'b000;

   localparam logic [CharWidth-1:0] MinCharBits = 4'd7;

   logic                rls_q, rls_n;
   logic                tmo_q, tmo_n;
   logic                thre_q, thre_n;
   logic                mstat_q, mstat_n;
   logic                thr_empty_d;
   logic                ier_thre_d;
   logic [CntWidth-1:0] cnt_q, cnt_n;

   logic                rxdr;
   logic                cnt_clr;
   logic                cnt_sat;
   logic [CntWidth-1:0] cnt_inc;
   logic [CharWidth-1:0] char_eff;
   logic [CntWidth-1:0] threshold;
   logic [IdWidth-1:0]  id_n;
   logic                status_n;

   // Timeout threshold in bit times; short frames are treated as 7 bits.
   always_comb begin
      char_eff  = (char_bits_i < MinCharBits) ? MinCharBits : char_bits_i;
      threshold = CntWidth'(TimeoutChars) * CntWidth'(char_eff);
   end

   always_comb begin
      rls_n    = rls_q;
      tmo_n    = tmo_q;
      thre_n   = thre_q;
      mstat_n  = mstat_q;
      cnt_n    = cnt_q;
      id_n     = IdNone;
      status_n = 1'b1;

      // Line status: gated at latch time; set beats the LSR read.
      if (rd_lsr_i)                   rls_n = 1'b0;
      if (rx_line_err_i && ier_i[2])  rls_n = 1'b1;

      rxdr = fifo_en_i ? (ier_i[0] & rx_fifo_trigger_i)
                       : (ier_i[0] & rx_data_ready_i);

      // Any FIFO activity or an empty/disabled FIFO restarts the inactivity count.
      cnt_clr = ~fifo_en_i | rx_fifo_empty_i | rx_fifo_push_i | rx_fifo_pop_i | rd_rhr_i;
      cnt_sat = (cnt_q == {CntWidth{1'b1}});
      cnt_inc = CntWidth'(cnt_q + CntWidth'(1));
      if (cnt_clr) begin
         cnt_n = '0;
      end else if (bit_tick_i && !cnt_sat) begin
         cnt_n = cnt_inc;
      end

      if (!cnt_clr && bit_tick_i && !cnt_sat && (cnt_inc == threshold)) tmo_n = 1'b1;
      if (rd_rhr_i || rx_fifo_pop_i || rx_fifo_push_i || !fifo_en_i)    tmo_n = 1'b0;

      // THR empty: new empty edge or enable edge while empty; clears win.
      if ((tx_thr_empty_i && !thr_empty_d) || (ier_i[1] && !ier_thre_d && tx_thr_empty_i))
         thre_n = 1'b1;
      if (wr_thr_i || !tx_thr_empty_i || (rd_isr_i && (isr_id_o == IdThre)))
         thre_n = 1'b0;

      if (rd_msr_i)      mstat_n = 1'b0;
      if (modem_delta_i) mstat_n = 1'b1;

      if (rls_n) begin
         id_n     = IdRls;
         status_n = 1'b0;
      end else if (rxdr) begin
         id_n     = IdRxdr;
         status_n = 1'b0;
      end else if (tmo_n && ier_i[0]) begin
         id_n     = IdTmo;
         status_n = 1'b0;
      end else if (thre_n && ier_i[1]) begin
         id_n     = IdThre;
         status_n = 1'b0;
      end else if (mstat_n && ier_i[3]) begin
         id_n     = IdMstat;
         status_n = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rls_q        <= 1'b0;
         tmo_q        <= 1'b0;
         thre_q       <= 1'b0;
         mstat_q      <= 1'b0;
         thr_empty_d  <= 1'b0;
         ier_thre_d   <= 1'b0;
         cnt_q        <= '0;
         isr_id_o     <= IdNone;
         isr_status_o <= 1'b1;
         irq_o        <= 1'b0;
      end else begin
         rls_q        <= rls_n;
         tmo_q        <= tmo_n;
         thre_q       <= thre_n;
         mstat_q      <= mstat_n;
         thr_empty_d  <= tx_thr_empty_i;
         ier_thre_d   <= ier_i[1];
         cnt_q        <= cnt_n;
         isr_id_o     <= id_n;
         isr_status_o <= status_n;
         irq_o        <= ~status_n;
      end
   end

   assign timeout_o = tmo_q;

endmodule

// File: tb/tb_uart_irq_scheduler.sv
// Directed self-checking bench for uart_irq_scheduler.
module tb_uart_irq_scheduler;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [3:0] ier_i;
   logic       fifo_en_i, rx_line_err_i, rx_data_ready_i, rx_fifo_trigger_i;
   logic       rx_fifo_empty_i, rx_fifo_push_i, rx_fifo_pop_i, tx_thr_empty_i;
   logic       modem_delta_i, bit_tick_i;
   logic [3:0] char_bits_i;
   logic       rd_lsr_i, rd_rhr_i, rd_msr_i, rd_isr_i, wr_thr_i;
   logic [2:0] isr_id_o;
   logic       isr_status_o, irq_o, timeout_o;

   int total = 0;
   int bad   = 0;

   uart_irq_scheduler #(.TimeoutChars(4), .CntWidth(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .ier_i(ier_i), .fifo_en_i(fifo_en_i),
      .rx_line_err_i(rx_line_err_i), .rx_data_ready_i(rx_data_ready_i),
      .rx_fifo_trigger_i(rx_fifo_trigger_i), .rx_fifo_empty_i(rx_fifo_empty_i),
      .rx_fifo_push_i(rx_fifo_push_i), .rx_fifo_pop_i(rx_fifo_pop_i),
      .tx_thr_empty_i(tx_thr_empty_i), .modem_delta_i(modem_delta_i),
      .bit_tick_i(bit_tick_i), .char_bits_i(char_bits_i),
      .rd_lsr_i(rd_lsr_i), .rd_rhr_i(rd_rhr_i), .rd_msr_i(rd_msr_i),
      .rd_isr_i(rd_isr_i), .wr_thr_i(wr_thr_i),
      .isr_id_o(isr_id_o), .isr_status_o(isr_status_o), .irq_o(irq_o),
      .timeout_o(timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive changes land 1 time unit after the edge; outputs are sampled there too.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic expect_out(input string tag, input int id, input int status, input int tmo);
      check({tag, ".id"},     int'(isr_id_o),     id);
      check({tag, ".status"}, int'(isr_status_o), status);
      check({tag, ".irq"},    int'(irq_o),        1 - status);
      check({tag, ".tmo"},    int'(timeout_o),    tmo);
   endtask

   task automatic ticks(input int n);
      bit_tick_i = 1'b1;
      for (int i = 0; i < n; i++) step();
      bit_tick_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; ier_i = 4'b0000; fifo_en_i = 1'b0; rx_line_err_i = 1'b0;
      rx_data_ready_i = 1'b0; rx_fifo_trigger_i = 1'b0; rx_fifo_empty_i = 1'b1;
      rx_fifo_push_i = 1'b0; rx_fifo_pop_i = 1'b0; tx_thr_empty_i = 1'b0;
      modem_delta_i = 1'b0; bit_tick_i = 1'b0; char_bits_i = 4'd10;
      rd_lsr_i = 1'b0; rd_rhr_i = 1'b0; rd_msr_i = 1'b0; rd_isr_i = 1'b0; wr_thr_i = 1'b0;
      #1;
      step();
      step();
      expect_out("reset", 0, 1, 0);
      rst_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         expect_out("idle", 0, 1, 0);
      end

      // Line error and modem delta together: RLS first, then MSTAT.
      ier_i = 4'b1111;
      rx_line_err_i = 1'b1; modem_delta_i = 1'b1;
      step();
      rx_line_err_i = 1'b0; modem_delta_i = 1'b0;
      expect_out("rls", 3, 0, 0);
      rd_lsr_i = 1'b1; step(); rd_lsr_i = 1'b0;
      expect_out("mstat", 0, 0, 0);
      rd_msr_i = 1'b1; step(); rd_msr_i = 1'b0;
      expect_out("mstat_clr", 0, 1, 0);

      // Non-FIFO data ready is a level source.
      rx_data_ready_i = 1'b1; step();
      expect_out("rxdr", 2, 0, 0);
      rx_data_ready_i = 1'b0; step();
      expect_out("rxdr_drop", 0, 1, 0);

      // Character timeout: 10-bit frames, 4 chars -> 40 bit times.
      ier_i = 4'b0001; fifo_en_i = 1'b1; rx_fifo_empty_i = 1'b0; char_bits_i = 4'd10;
      ticks(39);
      expect_out("tmo_39", 0, 1, 0);
      ticks(1);
      expect_out("tmo_40", 6, 0, 1);
      ier_i = 4'b0000; step();
      expect_out("tmo_masked", 0, 1, 1);
      ier_i = 4'b0001; step();
      expect_out("tmo_unmasked", 6, 0, 1);
      rd_rhr_i = 1'b1; step(); rd_rhr_i = 1'b0;
      expect_out("tmo_rhr", 0, 1, 0);

      // Push after 30 ticks restarts the count.
      ticks(30);
      rx_fifo_push_i = 1'b1; step(); rx_fifo_push_i = 1'b0;
      ticks(39);
      expect_out("push_39", 0, 1, 0);
      ticks(1);
      expect_out("push_40", 6, 0, 1);
      rx_fifo_pop_i = 1'b1; step(); rx_fifo_pop_i = 1'b0;
      expect_out("tmo_pop", 0, 1, 0);
      fifo_en_i = 1'b0; rx_fifo_empty_i = 1'b1;

      // THR empty edge, ISR read clear, re-enable edge, THR write clear.
      ier_i = 4'b0010; step();
      expect_out("thre_idle", 0, 1, 0);
      tx_thr_empty_i = 1'b1; step();
      expect_out("thre_edge", 1, 0, 0);
      rd_isr_i = 1'b1; step(); rd_isr_i = 1'b0;
      expect_out("thre_isr", 0, 1, 0);
      step(); step();
      expect_out("thre_held", 0, 1, 0);
      ier_i = 4'b0000; step();
      expect_out("thre_off", 0, 1, 0);
      ier_i = 4'b0010; step();
      expect_out("thre_reen", 1, 0, 0);
      wr_thr_i = 1'b1; step(); wr_thr_i = 1'b0;
      expect_out("thre_wr", 0, 1, 0);
      tx_thr_empty_i = 1'b0; step();

      // Set beats clear for RLS; reset beats everything.
      ier_i = 4'b1111;
      rx_line_err_i = 1'b1; rd_lsr_i = 1'b1; step();
      rx_line_err_i = 1'b0; rd_lsr_i = 1'b0;
      expect_out("rls_setwins", 3, 0, 0);
      step();
      expect_out("rls_hold", 3, 0, 0);
      rst_i = 1'b1; modem_delta_i = 1'b1; step();
      rst_i = 1'b0; modem_delta_i = 1'b0;
      expect_out("rst_mid", 0, 1, 0);
      step();
      expect_out("post_rst", 0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
